// File: rtl/debounce_scan_ctrl.sv
// debounce_scan_ctrl: time-shared debouncer for NSW switch inputs.
// A round-robin scanner accepts a level change on one channel immediately,
// then holds off all channels for HOLD_CYCLES clocks while that channel's
// contacts settle. One shared timer replaces a counter per channel.
// Optional feature macro: DBSCAN_IRQ_EN adds irq_ack/irq, a sticky
// interrupt that sets on any accepted edge and clears on acknowledge.
module debounce_scan_ctrl #(
  parameter int NSW         = 4,
  parameter int HOLD_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NSW-1:0]          sw,
  output logic [NSW-1:0]          db_level,
  output logic [NSW-1:0]          rise,
  output logic [NSW-1:0]          fall,
  output logic                    busy,
  output logic [$clog2(NSW)-1:0]  active_idx
`ifdef DBSCAN_IRQ_EN
  ,
  input  logic                    irq_ack,
  output logic                    irq
`endif
);

  localparam int TW = $clog2(HOLD_CYCLES);
  localparam int IW = $clog2(NSW);

  typedef enum logic {SCAN, HOLD} state_t;

  state_t          state;
  logic [NSW-1:0]  sync_a;
  logic [NSW-1:0]  sw_s;
  logic [IW-1:0]   ptr;
  logic [TW-1:0]   timer;

  // Next channel index in scan order, wrapping after the last channel.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
    if (idx == IW'(NSW - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  // Two-flop synchroniser bringing the raw pins into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= '0;
      sw_s   <= '0;
    end else begin
      sync_a <= sw;
      sw_s   <= sync_a;
    end
  end

  // Scan/hold controller: accept one change, then lock out for the hold time.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SCAN;
      ptr        <= '0;
      timer      <= '0;
      db_level   <= '0;
      rise       <= '0;
      fall       <= '0;
      busy       <= 1'b0;
      active_idx <= '0;
    end else begin
      rise <= '0;
      fall <= '0;
      case (state)
        SCAN: begin
          if (sw_s[ptr] != db_level[ptr]) begin
            db_level[ptr] <= sw_s[ptr];
            rise[ptr]     <= sw_s[ptr];
            fall[ptr]     <= ~sw_s[ptr];
            active_idx    <= ptr;
            timer         <= TW'(HOLD_CYCLES - 1);
            busy          <= 1'b1;
            state         <= HOLD;
          end else begin
            ptr <= wrap_inc(ptr);
          end
        end
        HOLD: begin
          if (timer == '0) begin
            busy  <= 1'b0;
            ptr   <= wrap_inc(active_idx);
            state <= SCAN;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= SCAN;
        end
      endcase
    end
  end

`ifdef DBSCAN_IRQ_EN
  // Sticky interrupt: set by a visible edge pulse, cleared by ack; set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else if ((|rise) || (|fall)) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule
